// File: rtl/pdm_pkg.sv
// Shared types for the PDM record/playback controller: FSM state encoding
// and the default amplitude sample width.
package pdm_pkg;

    localparam int SAMPLE_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RECORD,
        ST_PLAY_RD,
        ST_PLAY_WAIT,
        ST_PLAY_OUT
    } rec_state_t;

endpackage

// File: rtl/pdm_record_ctrl.sv
// Record/playback sequencer: captures amplitude samples into an external RAM
// after a microphone warm-up, then streams them back over a valid/ready port.
module pdm_record_ctrl
    import pdm_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int WARMUP   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rec_start,
    input  logic                play_start,
    input  logic                stop,
    input  logic [SAMPLE_W-1:0] amplitude,
    input  logic                amplitude_valid,
    output logic                mic_en,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [SAMPLE_W-1:0] rd_data,
    output logic [SAMPLE_W-1:0] play_data,
    output logic                play_valid,
    input  logic                play_ready,
    output logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done
);

    localparam int WARM_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

    rec_state_t          state_reg, state_next;
    logic [WARM_W-1:0]   warm_cnt_reg, warm_cnt_next;
    logic [ADDR_W:0]     length_reg, length_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic                wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic [SAMPLE_W-1:0] wr_data_reg, wr_data_next;
    logic [SAMPLE_W-1:0] play_data_reg, play_data_next;
    logic                play_valid_reg, play_valid_next;
    logic                done_reg, done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            warm_cnt_reg   <= '0;
            length_reg     <= '0;
            ptr_reg        <= '0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            play_data_reg  <= '0;
            play_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            warm_cnt_reg   <= warm_cnt_next;
            length_reg     <= length_next;
            ptr_reg        <= ptr_next;
            wr_en_reg      <= wr_en_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            play_data_reg  <= play_data_next;
            play_valid_reg <= play_valid_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        warm_cnt_next   = warm_cnt_reg;
        length_next     = length_reg;
        ptr_next        = ptr_reg;
        wr_en_next      = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        play_data_next  = play_data_reg;
        play_valid_next = play_valid_reg;
        done_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // rec_start takes priority when both start pulses coincide
                if (rec_start) begin
                    state_next    = (WARMUP == 0) ? ST_RECORD : ST_WARMUP;
                    warm_cnt_next = '0;
                    length_next   = '0;
                end else if (play_start) begin
                    if (length_reg == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_PLAY_RD;
                        ptr_next   = '0;
                    end
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    state_next  = ST_IDLE;
                    done_next   = 1'b1;
                    length_next = '0;
                end else if (amplitude_valid) begin
                    warm_cnt_next = warm_cnt_reg + 1'b1;
                    if (warm_cnt_reg == WARM_LAST) begin
                        state_next = ST_RECORD;
                    end
                end
            end
            ST_RECORD: begin
                // A sample arriving with stop is still written before leaving
                if (amplitude_valid) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = length_reg[ADDR_W-1:0];
                    wr_data_next = amplitude;
                    length_next  = length_reg + 1'b1;
                end
                if (stop || (amplitude_valid && (length_reg + 1'b1 == DEPTH_LEN))) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            ST_PLAY_RD, ST_PLAY_WAIT, ST_PLAY_OUT: begin
                if (stop) begin
                    state_next      = ST_IDLE;
                    play_valid_next = 1'b0;
                    done_next       = 1'b1;
                end else if (state_reg == ST_PLAY_RD) begin
                    state_next = ST_PLAY_WAIT;
                end else if (state_reg == ST_PLAY_WAIT) begin
                    play_data_next  = rd_data;
                    play_valid_next = 1'b1;
                    state_next      = ST_PLAY_OUT;
                end else if (play_ready) begin
                    play_valid_next = 1'b0;
                    ptr_next        = ptr_reg + 1'b1;
                    if ({1'b0, ptr_reg} + 1'b1 == length_reg) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_PLAY_RD;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mic_en     = (state_reg == ST_WARMUP) || (state_reg == ST_RECORD);
    assign busy       = (state_reg != ST_IDLE);
    assign rd_en      = (state_reg == ST_PLAY_RD);
    assign rd_addr    = ptr_reg;
    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign play_data  = play_data_reg;
    assign play_valid = play_valid_reg;
    assign length     = length_reg;
    assign done       = done_reg;

endmodule

// File: doc/pdm_record_ctrl.md
PDM_RECORD_CTRL -- requirements
Module: pdm_record_ctrl

Interface
REQ-001 Parameter ADDR_W, default 14, sample buffer address width; depth DEPTH = 2**ADDR_W.
REQ-002 Parameter SAMPLE_W, default 8, amplitude sample width.
REQ-003 Parameter WARMUP, default 4, number of amplitude samples discarded after mic enable.
REQ-004 clk  in  1  system clock (100 MHz); the block has one clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rec_start  in  1  single-cycle pulse, begin recording.
REQ-007 play_start  in  1  single-cycle pulse, begin playback.
REQ-008 stop  in  1  single-cycle pulse, end current operation.
REQ-009 amplitude  in  SAMPLE_W  sample from PDM capture front-end.
REQ-010 amplitude_valid  in  1  single-cycle qualifier for amplitude.
REQ-011 mic_en  out  1  enables the PDM front-end and microphone clock.
REQ-012 wr_en / wr_addr / wr_data  out  1 / ADDR_W / SAMPLE_W  buffer RAM write port.
REQ-013 rd_en / rd_addr  out  1 / ADDR_W  buffer RAM read request; rd_data  in  SAMPLE_W, valid exactly 1 cycle after rd_en.
REQ-014 play_data / play_valid  out  SAMPLE_W / 1; play_ready  in  1: playback stream handshake.
REQ-015 length  out  ADDR_W+1  number of samples held in the buffer.
REQ-016 busy  out  1  high in any state other than IDLE; done  out  1  single-cycle pulse when an operation ends.

Function
REQ-017 FSM states: IDLE, WARMUP, RECORD, PLAY_RD, PLAY_WAIT, PLAY_OUT.
REQ-018 IDLE + rec_start -> WARMUP: mic_en=1, warm-up counter=0, length=0.
REQ-019 WARMUP: each amplitude_valid increments the warm-up counter; no RAM write; after the WARMUP-th valid -> RECORD.
REQ-020 RECORD: each amplitude_valid -> wr_en=1 the next cycle, wr_addr=length, wr_data=amplitude; length increments in the same cycle.
REQ-021 RECORD ends when length reaches DEPTH (buffer full) or on stop: -> IDLE, mic_en=0, done=1 for one cycle; length holds its final value.
REQ-022 A stop coinciding with amplitude_valid in RECORD writes that sample first, then terminates.
REQ-023 Writes never exceed DEPTH; no amplitude_valid beyond full is written.
REQ-024 IDLE + play_start with length=0 -> stay IDLE, done=1 for one cycle.
REQ-025 IDLE + play_start with length>0 -> PLAY_RD with read pointer=0.
REQ-026 PLAY_RD: rd_en=1, rd_addr=pointer, one cycle -> PLAY_WAIT.
REQ-027 PLAY_WAIT: capture rd_data into play_data, play_valid=1 -> PLAY_OUT.
REQ-028 PLAY_OUT: play_data/play_valid are held stable until play_ready=1; on transfer, pointer increments; if pointer+1 = length -> IDLE with done=1, otherwise -> PLAY_RD.
REQ-029 stop in any PLAY_* state -> IDLE next cycle, play_valid=0, done=1; stop is the only case where play_valid drops without play_ready.
REQ-030 stop in WARMUP -> IDLE, mic_en=0, done=1, length=0.
REQ-031 rec_start/play_start while busy are ignored; simultaneous rec_start and play_start in IDLE: rec_start wins.
REQ-032 mic_en=1 only in WARMUP and RECORD.

Reset
REQ-033 rst_n low asynchronously forces IDLE; mic_en, wr_en, rd_en, play_valid, busy, done = 0; length, pointer, counters = 0; play_data = 0.
REQ-034 Reset mid-RECORD discards the recording (length=0); no write is issued after reset assertion.
REQ-035 Exit from reset is synchronous to clk; first state change is no earlier than the first clk edge after rst_n rises.

Structure
REQ-036 A shared package pdm_pkg holds the FSM state enum (rec_state_t) and the SAMPLE_W default.
REQ-037 The block is a single module with no sub-modules; the RAM is external to it.

Verification
REQ-038 rec_start with WARMUP=4, then 10 valid samples 1..10 -> first 4 dropped; writes to addr 0..5 with data 5..10; stop -> length=6, done pulse, mic_en=0.
REQ-039 ADDR_W=3, continuous samples -> exactly 8 writes (addr 0..7), auto return to IDLE with done; the 9th valid sample is not written.
REQ-040 Playback of length=3, play_ready held low 5 cycles per sample -> play_data stable while waiting; stream 3 samples matching RAM contents, done after the 3rd transfer.
REQ-041 play_start with length=0 -> done pulse next cycle, no rd_en, busy stays 0.
REQ-042 stop in the same cycle as amplitude_valid during RECORD -> sample written, length incremented, then IDLE.
REQ-043 rst_n asserted mid-PLAY_OUT -> play_valid=0 and IDLE immediately (asynchronous); length=0 afterwards.
